// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_pkg / fetch_pc_unit
//
// Fetch-stage next-PC generator. It holds the IF program counter and a
// direct-mapped branch target buffer (BTB). A BTB hit combined with the
// direction bit from the downstream local-history predictor steers fetch.
// Branches and jumps are resolved from EX. A mispredict raises flush_o in the
// same cycle and redirects the PC on the next edge. Two saturating counters
// track resolved branches and mispredicts.
//
// Ports
//   clk               in   1          clock, all state on rising edge
//   rst               in   1          asynchronous active-low reset
//   is_stall          in   1          pipeline stall: IF holds, EX resolve suppressed
//   br_pred_i         in   1          predictor direction for pc_IF_o (1 = taken)
//   pc_IF_o           out  32         current fetch PC
//   pred_taken_IF_o   out  1          fetch predicted taken
//   pred_target_IF_o  out  32         predicted next fetch address
//   opcode_EX         in   opcode     opcode of the instruction in EX
//   pc_EX             in   32         PC of the instruction in EX
//   br_en_EX          in   1          conditional branch outcome
//   target_EX         in   32         computed branch/jump target
//   pred_taken_EX     in   1          prediction carried along with the EX instr
//   pred_target_EX    in   32         predicted target carried along with it
//   flush_o           out  1          squash IF/ID (combinational)
//   br_count_o        out  CNT_WIDTH  resolved branch/jump count (saturating)
//   mispred_count_o   out  CNT_WIDTH  mispredict count (saturating)
// -----------------------------------------------------------------------------
package fetch_pc_pkg;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
endpackage

module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter int unsigned BTB_IDX_BITS  = 5,
  parameter int unsigned PC_BIT_OFFSET = 2,
  parameter logic [31:0] RESET_PC      = 32'h4000_0060,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_stall,
  input  logic                 br_pred_i,
  output logic [31:0]          pc_IF_o,
  output logic                 pred_taken_IF_o,
  output logic [31:0]          pred_target_IF_o,
  input  rv32i_opcode          opcode_EX,
  input  logic [31:0]          pc_EX,
  input  logic                 br_en_EX,
  input  logic [31:0]          target_EX,
  input  logic                 pred_taken_EX,
  input  logic [31:0]          pred_target_EX,
  output logic                 flush_o,
  output logic [CNT_WIDTH-1:0] br_count_o,
  output logic [CNT_WIDTH-1:0] mispred_count_o
);

  localparam int unsigned ENTRIES = 1 << BTB_IDX_BITS;
  localparam int unsigned IDX_LSB = PC_BIT_OFFSET;
  localparam int unsigned IDX_MSB = BTB_IDX_BITS + PC_BIT_OFFSET - 1;
  localparam int unsigned TAG_LSB = BTB_IDX_BITS + PC_BIT_OFFSET;
  localparam int unsigned TAG_W   = 32 - TAG_LSB;

  typedef logic [BTB_IDX_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]        tag_t;

  // BTB storage
  logic [ENTRIES-1:0] btb_valid;
  tag_t               btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [CNT_WIDTH-1:0] br_count_q;
  logic [CNT_WIDTH-1:0] mispred_count_q;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup
  // ---------------------------------------------------------------------------
  idx_t        if_idx;
  tag_t        if_tag;
  logic        btb_hit;
  logic [31:0] pc_plus4;

  assign if_idx   = pc_q[IDX_MSB:IDX_LSB];
  assign if_tag   = pc_q[31:TAG_LSB];
  assign btb_hit  = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign pc_plus4 = pc_q + 32'd4;

  assign pc_IF_o          = pc_q;
  // Gated by rst so nothing downstream sees a prediction while in reset.
  assign pred_taken_IF_o  = rst && btb_hit && br_pred_i;
  assign pred_target_IF_o = btb_hit ? btb_target[if_idx] : pc_plus4;

  // ---------------------------------------------------------------------------
  // EX-side resolution
  // ---------------------------------------------------------------------------
  logic        is_ctrl;
  logic        res;
  logic        actual_taken;
  logic        mispred;
  logic [31:0] redirect_pc;
  idx_t        ex_idx;
  tag_t        ex_tag;

  assign is_ctrl      = (opcode_EX == op_br) || (opcode_EX == op_jal) ||
                        (opcode_EX == op_jalr);
  assign res          = !is_stall && is_ctrl;
  assign actual_taken = (opcode_EX == op_jal) || (opcode_EX == op_jalr) ||
                        ((opcode_EX == op_br) && br_en_EX);
  // A taken prediction with the wrong target is also a mispredict.
  assign mispred      = res && ((actual_taken != pred_taken_EX) ||
                                (actual_taken && (pred_target_EX != target_EX)));
  assign flush_o      = rst && mispred;
  assign redirect_pc  = actual_taken ? target_EX : (pc_EX + 32'd4);
  assign ex_idx       = pc_EX[IDX_MSB:IDX_LSB];
  assign ex_tag       = pc_EX[31:TAG_LSB];

  // ---------------------------------------------------------------------------
  // Next-PC selection. Mispredict cannot coincide with a stall because res
  // already excludes is_stall, so the ordering below is only for clarity.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    pc_d = pc_plus4;
    if (mispred)              pc_d = redirect_pc;
    else if (is_stall)        pc_d = pc_q;
    else if (pred_taken_IF_o) pc_d = pred_target_IF_o;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q            <= RESET_PC;
      btb_valid       <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (res && actual_taken) btb_valid[ex_idx] <= 1'b1;
      if (res && (br_count_q != '1))
        br_count_q <= br_count_q + CNT_WIDTH'(1);
      if (mispred && (mispred_count_q != '1))
        mispred_count_q <= mispred_count_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: tag/target arrays are deliberately left out of reset; the valid bits
  // alone make stale contents invisible, and an unreset array maps to plain RAM.
  // Reads are combinational from these registers, so a same-cycle lookup at
  // the index being written returns the old contents.
  always_ff @(posedge clk) begin
    if (res && actual_taken) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= target_EX;
    end
  end

  assign br_count_o      = br_count_q;
  assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Directed test of fetch_pc_unit with hand-computed expectations. Inputs are
// driven 1 ns after the rising edge and outputs are sampled 1 ns later, well
// away from the active edge. CNT_WIDTH is 4 so counter saturation is reachable.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;
  import fetch_pc_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          is_stall;
  logic          br_pred_i;
  logic [31:0]   pc_IF_o;
  logic          pred_taken_IF_o;
  logic [31:0]   pred_target_IF_o;
  rv32i_opcode   opcode_EX;
  logic [31:0]   pc_EX;
  logic          br_en_EX;
  logic [31:0]   target_EX;
  logic          pred_taken_EX;
  logic [31:0]   pred_target_EX;
  logic          flush_o;
  logic [CW-1:0] br_count_o;
  logic [CW-1:0] mispred_count_o;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pc_unit #(
    .BTB_IDX_BITS (5),
    .PC_BIT_OFFSET(2),
    .RESET_PC     (32'h4000_0060),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .is_stall        (is_stall),
    .br_pred_i       (br_pred_i),
    .pc_IF_o         (pc_IF_o),
    .pred_taken_IF_o (pred_taken_IF_o),
    .pred_target_IF_o(pred_target_IF_o),
    .opcode_EX       (opcode_EX),
    .pc_EX           (pc_EX),
    .br_en_EX        (br_en_EX),
    .target_EX       (target_EX),
    .pred_taken_EX   (pred_taken_EX),
    .pred_target_EX  (pred_target_EX),
    .flush_o         (flush_o),
    .br_count_o      (br_count_o),
    .mispred_count_o (mispred_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then wait 1 ns so inputs change away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    opcode_EX      = op_imm;
    pc_EX          = 32'h0;
    br_en_EX       = 1'b0;
    target_EX      = 32'h0;
    pred_taken_EX  = 1'b0;
    pred_target_EX = 32'h0;
  endtask

  task automatic ex_set(input rv32i_opcode op, input logic [31:0] pc, input logic en,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    opcode_EX      = op;
    pc_EX          = pc;
    br_en_EX       = en;
    target_EX      = tgt;
    pred_taken_EX  = pt;
    pred_target_EX = ptgt;
  endtask

  task automatic check_counts(input string tag, input int br, input int mis);
    check({tag, "_br"},  32'(br_count_o),      32'(br));
    check({tag, "_mis"}, 32'(mispred_count_o), 32'(mis));
  endtask

  initial begin
    rst       = 1'b0;
    is_stall  = 1'b0;
    br_pred_i = 1'b1;
    // A mispredicting JAL in EX during reset must not raise flush.
    ex_set(op_jal, 32'h4000_0200, 1'b0, 32'h4000_0400, 1'b0, 32'h0);
    step();
    step();

    // 1: reset state
    check("rst_pc", pc_IF_o, 32'h4000_0060);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_pred_taken", 32'(pred_taken_IF_o), 32'd0);
    check_counts("rst", 0, 0);
    ex_idle();
    rst = 1'b1;
    #1;
    check("cold_miss_taken", 32'(pred_taken_IF_o), 32'd0);
    check("cold_miss_target", pred_target_IF_o, 32'h4000_0064);

    // 2: sequential fetch, then stall
    step(); check("seq_pc1", pc_IF_o, 32'h4000_0064);
    step(); check("seq_pc2", pc_IF_o, 32'h4000_0068);
    step(); check("seq_pc3", pc_IF_o, 32'h4000_006C);
    is_stall = 1'b1;
    step(); check("stall_hold", pc_IF_o, 32'h4000_006C);
    is_stall = 1'b0;

    // 3: cold taken BEQ predicted not-taken -> flush and redirect
    ex_set(op_br, 32'h4000_0080, 1'b1, 32'h4000_0100, 1'b0, 32'h4000_0084);
    #1;
    check("beq_flush", 32'(flush_o), 32'd1);
    step();
    ex_idle();
    #1;
    check("beq_redirect", pc_IF_o, 32'h4000_0100);
    check_counts("beq", 1, 1);

    // 4: alias at index 0 with a different tag -> miss
    check("alias_taken", 32'(pred_taken_IF_o), 32'd0);
    check("alias_target", pred_target_IF_o, 32'h4000_0104);
    step(); check("alias_next", pc_IF_o, 32'h4000_0104);

    // Not-taken branch predicted taken: redirect back to 0x80 (pc_EX+4)
    ex_set(op_br, 32'h4000_007C, 1'b0, 32'h4000_0500, 1'b1, 32'h4000_0500);
    #1;
    check("nt_flush", 32'(flush_o), 32'd1);
    step();
    ex_idle();
    #1;
    check("nt_redirect", pc_IF_o, 32'h4000_0080);
    check_counts("nt", 2, 2);

    // Refetch of the trained BEQ -> BTB hit, predicted taken
    check("hit_taken", 32'(pred_taken_IF_o), 32'd1);
    check("hit_target", pred_target_IF_o, 32'h4000_0100);
    step(); check("hit_next", pc_IF_o, 32'h4000_0100);

    // Correct prediction resolves without flush
    ex_set(op_br, 32'h4000_0080, 1'b1, 32'h4000_0100, 1'b1, 32'h4000_0100);
    #1;
    check("ok_flush", 32'(flush_o), 32'd0);
    step();
    ex_idle();
    #1;
    check("ok_next", pc_IF_o, 32'h4000_0104);
    check_counts("ok", 3, 2);

    // 5: wrong-target JALR during stall -> nothing happens
    is_stall = 1'b1;
    ex_set(op_jalr, 32'h4000_0090, 1'b0, 32'h4000_0300, 1'b1, 32'h4000_0094);
    #1;
    check("stall_flush", 32'(flush_o), 32'd0);
    step();
    check("stall_pc", pc_IF_o, 32'h4000_0104);
    check_counts("stall", 3, 2);
    is_stall = 1'b0;
    #1;
    check("unstall_flush", 32'(flush_o), 32'd1);
    step();
    ex_idle();
    #1;
    check("unstall_redirect", pc_IF_o, 32'h4000_0300);
    check_counts("unstall", 4, 3);

    // Same-cycle read/write at index 0: lookup sees old (aliased) entry
    ex_set(op_jal, 32'h4000_0300, 1'b0, 32'h4000_0500, 1'b1, 32'h4000_0500);
    #1;
    check("rw_old_taken", 32'(pred_taken_IF_o), 32'd0);
    check("rw_flush", 32'(flush_o), 32'd0);
    step();
    ex_idle();
    #1;
    check("rw_next", pc_IF_o, 32'h4000_0304);
    // Return to 0x300 via a not-taken mispredict at 0x2FC
    ex_set(op_br, 32'h4000_02FC, 1'b0, 32'h4000_0700, 1'b1, 32'h4000_0700);
    step();
    ex_idle();
    br_pred_i = 1'b0;
    #1;
    check("rw_back_pc", pc_IF_o, 32'h4000_0300);
    check_counts("rw", 6, 4);
    check("gate_taken", 32'(pred_taken_IF_o), 32'd0);
    check("gate_target", pred_target_IF_o, 32'h4000_0500);
    br_pred_i = 1'b1;
    #1;
    check("new_hit_taken", 32'(pred_taken_IF_o), 32'd1);
    step(); check("new_hit_next", pc_IF_o, 32'h4000_0500);

    // 6: 17 mispredicted JALs saturate both 4-bit counters; the JAL sits at
    // RESET_PC so its BTB entry would hit after reset if valid bits survived.
    ex_set(op_jal, 32'h4000_0060, 1'b0, 32'h4000_2000, 1'b0, 32'h0);
    for (int i = 0; i < 17; i++) step();
    check_counts("sat", 15, 15);
    check("sat_pc", pc_IF_o, 32'h4000_2000);

    // Asynchronous reset mid-cycle with the JAL still in EX
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc", pc_IF_o, 32'h4000_0060);
    check("arst_flush", 32'(flush_o), 32'd0);
    check_counts("arst", 0, 0);
    ex_idle();
    step();
    rst = 1'b1;
    #1;
    check("arst_btb_miss", 32'(pred_taken_IF_o), 32'd0);
    check("arst_btb_target", pred_target_IF_o, 32'h4000_0064);
    step(); check("arst_first_fetch", pc_IF_o, 32'h4000_0064);
    check_counts("arst_after", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
